rhs_axil_cfg_slave: RTL and testbench

RHS_AXIL_CFG_SLAVE -- requirements
Module: rhs_axil_cfg_slave

---
 rtl/rhs_axil_cfg_slave.sv | 213 +++++++++++++++++++++
 tb/tb_rhs_axil_cfg_slave.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rhs_axil_cfg_slave.sv
// AXI4-Lite configuration register slave with eight word registers that drive the cfg_* outputs.
// Optional macro RHS_CFG_WSTRB_EN enables byte-strobe writes; otherwise full words are written.
module rhs_axil_cfg_slave #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [7:0]            cfg_ctrl,
  output logic [31:0]           cfg_stim_mag,
  output logic [15:0]           cfg_pkt_len,
  output logic [1:0]            cfg_zscale,
  output logic [7:0]            cfg_zcycle,
  output logic                  cfg_stim_mono,
  output logic [4:0]            cfg_stim_neg,
  output logic [4:0]            cfg_stim_pos,
  output logic [15:0]           cfg_pulse_width,
  output logic [15:0]           cfg_ipd,
  output logic [7:0]            cfg_num_pulse,
  output logic                  cfg_update,
  output logic [1:0]            dbg_wstate,
  output logic                  dbg_rstate
);

  // Handshake rule on every channel: a transfer happens on a rising edge where valid
  // and ready are both high; valid never waits on ready and is held until accepted.
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;
  logic                  aw_done_q, w_done_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [31:0]           rdata_q;
  logic                  aw_hs, w_hs, ar_hs;
  logic                  wr_err, rd_err;
  logic [31:0]           wr_mask, wr_word;
  logic [31:0]           reg_words [8];
  logic                  unused_ok;

  assign s_axi_awready = !areset && (w_state_q == W_IDLE) && !aw_done_q;
  assign s_axi_wready  = !areset && (w_state_q == W_IDLE) && !w_done_q;
  assign s_axi_arready = !areset && (r_state_q == R_IDLE);
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign dbg_wstate    = w_state_q;
  assign dbg_rstate    = r_state_q;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign wr_err = |awaddr_q[ADDR_WIDTH-1:5];
  assign rd_err = |s_axi_araddr[ADDR_WIDTH-1:5];

  // Register words as seen on the bus; unimplemented bits are tied to zero.
  always_comb begin
    reg_words[0] = {24'd0, cfg_ctrl};
    reg_words[1] = cfg_stim_mag;
    reg_words[2] = {16'd0, cfg_pkt_len};
    reg_words[3] = {22'd0, cfg_zscale, cfg_zcycle};
    reg_words[4] = {21'd0, cfg_stim_mono, cfg_stim_neg, cfg_stim_pos};
    reg_words[5] = {16'd0, cfg_pulse_width};
    reg_words[6] = {16'd0, cfg_ipd};
    reg_words[7] = {24'd0, cfg_num_pulse};
  end

`ifdef RHS_CFG_WSTRB_EN
  assign wr_mask   = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, awaddr_q[1:0], s_axi_araddr[1:0]};
`else
  assign wr_mask   = 32'hFFFF_FFFF;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, awaddr_q[1:0], s_axi_araddr[1:0],
                       s_axi_wstrb, wstrb_q};
`endif

  // Merge new bytes into the current word so strobed-off bytes keep their value.
  assign wr_word = (reg_words[awaddr_q[4:2]] & ~wr_mask) | (wdata_q & wr_mask);

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:   if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) w_state_d = W_COMMIT;
      W_COMMIT: w_state_d = W_RESP;
      W_RESP:   if (bvalid_q && s_axi_bready) w_state_d = W_IDLE;
      default:  w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_RESP;
      R_RESP:  if (rvalid_q && s_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q       <= W_IDLE;
      aw_done_q       <= 1'b0;
      w_done_q        <= 1'b0;
      awaddr_q        <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      bvalid_q        <= 1'b0;
      bresp_q         <= RESP_OKAY;
      cfg_update      <= 1'b0;
      cfg_ctrl        <= '0;
      cfg_stim_mag    <= '0;
      cfg_pkt_len     <= '0;
      cfg_zscale      <= '0;
      cfg_zcycle      <= '0;
      cfg_stim_mono   <= 1'b0;
      cfg_stim_neg    <= '0;
      cfg_stim_pos    <= '0;
      cfg_pulse_width <= '0;
      cfg_ipd         <= '0;
      cfg_num_pulse   <= '0;
    end else begin
      w_state_q  <= w_state_d;
      cfg_update <= 1'b0;
      if (aw_hs) begin
        awaddr_q  <= s_axi_awaddr;
        aw_done_q <= 1'b1;
      end
      if (w_hs) begin
        wdata_q  <= s_axi_wdata;
        wstrb_q  <= s_axi_wstrb;
        w_done_q <= 1'b1;
      end
      if (w_state_q == W_COMMIT) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
        if (!wr_err) begin
          cfg_update <= 1'b1;
          case (awaddr_q[4:2])
            3'd0: cfg_ctrl     <= wr_word[7:0];
            3'd1: cfg_stim_mag <= wr_word;
            3'd2: cfg_pkt_len  <= wr_word[15:0];
            3'd3: begin
              cfg_zscale <= wr_word[9:8];
              cfg_zcycle <= wr_word[7:0];
            end
            3'd4: begin
              cfg_stim_mono <= wr_word[10];
              cfg_stim_neg  <= wr_word[9:5];
              cfg_stim_pos  <= wr_word[4:0];
            end
            3'd5: cfg_pulse_width <= wr_word[15:0];
            3'd6: cfg_ipd         <= wr_word[15:0];
            3'd7: cfg_num_pulse   <= wr_word[7:0];
          endcase
        end
      end
      // bvalid rises one edge after the commit edge, then holds until bready.
      if (w_state_q == W_RESP) begin
        if (!bvalid_q) bvalid_q <= 1'b1;
        else if (s_axi_bready) bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        rdata_q  <= rd_err ? 32'd0 : reg_words[s_axi_araddr[4:2]];
      end else if (rvalid_q && s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rhs_axil_cfg_slave.sv
// Directed testbench for rhs_axil_cfg_slave; inputs change on the falling edge, outputs are sampled there.
module tb_rhs_axil_cfg_slave;

  logic        aclk = 1'b0;
  logic        areset;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [7:0]  cfg_ctrl, cfg_zcycle, cfg_num_pulse;
  logic [31:0] cfg_stim_mag;
  logic [15:0] cfg_pkt_len, cfg_pulse_width, cfg_ipd;
  logic [1:0]  cfg_zscale;
  logic        cfg_stim_mono, cfg_update;
  logic [4:0]  cfg_stim_neg, cfg_stim_pos;
  logic [1:0]  dbg_wstate;
  logic        dbg_rstate;

  int errors = 0;
  int checks = 0;
  int upd_cnt = 0;

  always #5 aclk = ~aclk;

  rhs_axil_cfg_slave #(.ADDR_WIDTH(6)) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .cfg_ctrl(cfg_ctrl), .cfg_stim_mag(cfg_stim_mag), .cfg_pkt_len(cfg_pkt_len),
    .cfg_zscale(cfg_zscale), .cfg_zcycle(cfg_zcycle), .cfg_stim_mono(cfg_stim_mono),
    .cfg_stim_neg(cfg_stim_neg), .cfg_stim_pos(cfg_stim_pos), .cfg_pulse_width(cfg_pulse_width),
    .cfg_ipd(cfg_ipd), .cfg_num_pulse(cfg_num_pulse), .cfg_update(cfg_update),
    .dbg_wstate(dbg_wstate), .dbg_rstate(dbg_rstate)
  );

  always @(negedge aclk) if (cfg_update === 1'b1) upd_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    int n;
    logic aw_hs, w_hs;
    @(negedge aclk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge aclk);
      n++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
    end
    lat = 0;
    while (bvalid !== 1'b1 && lat < 20) begin
      @(negedge aclk);
      lat++;
    end
    checks++;
    if (awvalid || wvalid || bvalid !== 1'b1) begin
      errors++;
      $display("FAIL write_timeout addr=%h: got bvalid=%b, required 1 within 20 cycles", a, bvalid);
    end
    resp = bresp;
    @(negedge aclk);
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, output logic [31:0] data, output logic [1:0] resp);
    int n;
    logic hs;
    @(negedge aclk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      hs = arvalid && arready;
      @(negedge aclk);
      n++;
      if (hs) arvalid = 1'b0;
    end
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (arvalid || rvalid !== 1'b1) begin
      errors++;
      $display("FAIL read_timeout addr=%h: got rvalid=%b, required 1 within 20 cycles", a, rvalid);
    end
    data = rdata;
    resp = rresp;
    @(negedge aclk);
    rready = 1'b0; arvalid = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    awaddr = '0; awprot = 3'b101; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = 3'b010; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, cfg_update} !== 6'd0) begin
      errors++;
      $display("FAIL reset_handshake: got %b, required 000000",
               {awready, wready, bvalid, arready, rvalid, cfg_update});
    end
    checks++;
    if ({bresp, rresp, rdata} !== 36'd0) begin
      errors++;
      $display("FAIL reset_resp: got bresp=%b rresp=%b rdata=%h, required all 0", bresp, rresp, rdata);
    end
    checks++;
    if ({cfg_ctrl, cfg_stim_mag, cfg_pkt_len, cfg_zscale, cfg_zcycle, cfg_stim_mono, cfg_stim_neg,
         cfg_stim_pos, cfg_pulse_width, cfg_ipd, cfg_num_pulse} !== 117'd0) begin
      errors++;
      $display("FAIL reset_cfg: got nonzero cfg outputs, required all 0");
    end
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL idle_ready: got aw/w/ar ready=%b, required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_mag();
    logic [1:0] resp;
    logic [31:0] data;
    int lat, u0;
    u0 = upd_cnt;
    do_write(6'h04, 32'h80FF_80FF, 4'hF, resp, lat);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL mag_bresp: got %b, required 00", resp); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL mag_b_latency: got %0d, required 2", lat); end
    checks++;
    if (cfg_stim_mag !== 32'h80FF_80FF) begin
      errors++; $display("FAIL mag_cfg: got %h, required 80ff80ff", cfg_stim_mag);
    end
    checks++;
    if (upd_cnt - u0 !== 1) begin
      errors++; $display("FAIL mag_update: got %0d pulses, required 1", upd_cnt - u0);
    end
    do_read(6'h04, data, resp);
    checks++;
    if (data !== 32'h80FF_80FF || resp !== 2'b00) begin
      errors++; $display("FAIL mag_read: got %h/%b, required 80ff80ff/00", data, resp);
    end
  endtask

  task automatic test_fields();
    logic [1:0] resp;
    logic [31:0] data;
    int lat;
    do_write(6'h0C, 32'h0000_0304, 4'hF, resp, lat);
    do_write(6'h10, 32'h0000_0251, 4'hF, resp, lat);
    checks++;
    if ({cfg_zscale, cfg_zcycle} !== {2'd3, 8'd4}) begin
      errors++; $display("FAIL zfields: got zscale=%0d zcycle=%0d, required 3/4", cfg_zscale, cfg_zcycle);
    end
    checks++;
    if ({cfg_stim_mono, cfg_stim_neg, cfg_stim_pos} !== {1'b0, 5'd18, 5'd17}) begin
      errors++;
      $display("FAIL stim_fields: got mono=%0d neg=%0d pos=%0d, required 0/18/17",
               cfg_stim_mono, cfg_stim_neg, cfg_stim_pos);
    end
    do_read(6'h10, data, resp);
    checks++;
    if (data !== 32'h0000_0251) begin errors++; $display("FAIL stim_read: got %h, required 00000251", data); end
    do_write(6'h1C, 32'hFFFF_FFFF, 4'hF, resp, lat);
    do_read(6'h1F, data, resp);
    checks++;
    if (data !== 32'h0000_00FF || resp !== 2'b00 || cfg_num_pulse !== 8'hFF) begin
      errors++;
      $display("FAIL num_pulse_unimpl: got rdata=%h rresp=%b cfg=%h, required 000000ff/00/ff",
               data, resp, cfg_num_pulse);
    end
  endtask

  task automatic test_w_before_aw();
    int n, bad;
    logic [1:0] first_resp;
    @(negedge aclk);
    wdata = 32'h0000_0023; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    checks++;
    if (wready !== 1'b1) begin errors++; $display("FAIL wfirst_wready: got %b, required 1", wready); end
    @(negedge aclk);
    wvalid = 1'b0;
    checks++;
    if ({wready, awready} !== 2'b01) begin
      errors++; $display("FAIL wfirst_pending: got wready/awready=%b, required 01", {wready, awready});
    end
    repeat (2) @(negedge aclk);
    awaddr = 6'h00; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
    first_resp = bresp;
    bad = 0;
    repeat (5) begin
      if (bvalid !== 1'b1 || bresp !== first_resp) bad++;
      @(negedge aclk);
    end
    checks++;
    if (bad != 0 || first_resp !== 2'b00) begin
      errors++; $display("FAIL b_hold: got %0d unstable cycles, bresp=%b, required 0/00", bad, first_resp);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || cfg_ctrl !== 8'h23) begin
      errors++; $display("FAIL wfirst_done: got bvalid=%b ctrl=%h, required 0/23", bvalid, cfg_ctrl);
    end
  endtask

  task automatic test_slverr();
    logic [1:0] resp;
    logic [31:0] data;
    int lat, u0;
    logic [116:0] exp_cfg;
    exp_cfg = {8'h23, 32'h80FF_80FF, 16'h0, 2'd3, 8'd4, 1'b0, 5'd18, 5'd17, 16'h0, 16'h0, 8'hFF};
    u0 = upd_cnt;
    do_write(6'h24, 32'hDEAD_BEEF, 4'hF, resp, lat);
    checks++;
    if (resp !== 2'b10) begin errors++; $display("FAIL err_bresp: got %b, required 10", resp); end
    do_write(6'h3C, 32'h1234_5678, 4'hF, resp, lat);
    checks++;
    if (resp !== 2'b10) begin errors++; $display("FAIL err_bresp_top: got %b, required 10", resp); end
    checks++;
    if (upd_cnt != u0) begin errors++; $display("FAIL err_update: got %0d pulses, required 0", upd_cnt - u0); end
    checks++;
    if ({cfg_ctrl, cfg_stim_mag, cfg_pkt_len, cfg_zscale, cfg_zcycle, cfg_stim_mono, cfg_stim_neg,
         cfg_stim_pos, cfg_pulse_width, cfg_ipd, cfg_num_pulse} !== exp_cfg) begin
      errors++; $display("FAIL err_cfg_changed: got mag=%h ctrl=%h, required 80ff80ff/23", cfg_stim_mag, cfg_ctrl);
    end
    do_read(6'h24, data, resp);
    checks++;
    if (data !== 32'd0 || resp !== 2'b10) begin
      errors++; $display("FAIL err_read: got %h/%b, required 00000000/10", data, resp);
    end
  endtask

  task automatic test_wstrb();
    logic [1:0] resp;
    logic [31:0] data, exp;
    int lat;
`ifdef RHS_CFG_WSTRB_EN
    exp = 32'h80FF_CCFF;
`else
    exp = 32'hAABB_CCDD;
`endif
    do_write(6'h04, 32'h80FF_80FF, 4'hF, resp, lat);
    do_write(6'h04, 32'hAABB_CCDD, 4'b0010, resp, lat);
    do_read(6'h04, data, resp);
    checks++;
    if (data !== exp || cfg_stim_mag !== exp) begin
      errors++; $display("FAIL wstrb: got rdata=%h cfg=%h, required %h", data, cfg_stim_mag, exp);
    end
  endtask

  task automatic test_same_cycle();
    logic [1:0] resp;
    logic [31:0] data;
    int lat, n;
    do_write(6'h18, 32'h0000_1111, 4'hF, resp, lat);
    @(negedge aclk);
    awaddr = 6'h18; awvalid = 1'b1; wdata = 32'h0000_2222; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 6'h18; arvalid = 1'b1; rready = 1'b0;
    checks++;
    if (arready !== 1'b1 || bvalid !== 1'b0) begin
      errors++; $display("FAIL concur_ar: got arready=%b bvalid=%b, required 1/0", arready, bvalid);
    end
    @(negedge aclk);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0000_1111 || cfg_ipd !== 16'h2222) begin
      errors++;
      $display("FAIL read_during_commit: got rvalid=%b rdata=%h ipd=%h, required 1/00001111/2222",
               rvalid, rdata, cfg_ipd);
    end
    rready = 1'b1;
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++; $display("FAIL concur_b: got bvalid=%b bresp=%b, required 1/00", bvalid, bresp);
    end
    @(negedge aclk);
    bready = 1'b0; rready = 1'b0;
    do_read(6'h18, data, resp);
    checks++;
    if (data !== 32'h0000_2222) begin errors++; $display("FAIL ipd_after: got %h, required 00002222", data); end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] resp;
    logic [31:0] data;
    int lat, seen;
    @(negedge aclk);
    awaddr = 6'h08; awvalid = 1'b1; wdata = 32'h0000_1234; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    checks++;
    if ({awready, wready} !== 2'b11) begin
      errors++; $display("FAIL mid_ready: got %b, required 11", {awready, wready});
    end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; areset = 1'b1;
    @(negedge aclk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, cfg_update, bresp, rresp, rdata} !== 42'd0 ||
        {cfg_ctrl, cfg_stim_mag, cfg_pkt_len, cfg_num_pulse, cfg_ipd} !== 80'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got bvalid=%b pkt_len=%h mag=%h, required all 0",
               bvalid, cfg_pkt_len, cfg_stim_mag);
    end
    areset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge aclk);
      if (bvalid !== 1'b0) seen++;
    end
    bready = 1'b0;
    checks++;
    if (seen != 0 || cfg_pkt_len !== 16'h0) begin
      errors++; $display("FAIL mid_no_resp: got %0d bvalid cycles pkt_len=%h, required 0/0000", seen, cfg_pkt_len);
    end
    do_write(6'h08, 32'h0000_0055, 4'hF, resp, lat);
    checks++;
    if (resp !== 2'b00 || lat !== 2 || cfg_pkt_len !== 16'h0055) begin
      errors++; $display("FAIL post_reset_write: got resp=%b lat=%0d pkt_len=%h, required 00/2/0055",
                         resp, lat, cfg_pkt_len);
    end
    do_read(6'h08, data, resp);
    checks++;
    if (data !== 32'h0000_0055 || resp !== 2'b00) begin
      errors++; $display("FAIL post_reset_read: got %h/%b, required 00000055/00", data, resp);
    end
  endtask

  initial begin
    test_reset();
    test_mag();
    test_fields();
    test_w_before_aw();
    test_slverr();
    test_wstrb();
    test_same_cycle();
    test_reset_midflight();
    repeat (2) @(negedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
